opl_write_scheduler: RTL and testbench
======================================

# opl_write_scheduler

Serializes YM3526 register writes from the sound CPU onto the shared write bus of the two `jtopl` instances in the dual-OPL sound board. Requests are queued as (chip, register, data) triples in a small FIFO. Each is issued as an address-phase strobe followed by a data-phase strobe. A per-chip recovery timer, counted in OPL clock-enable ticks, enforces the minimum spacing the chip needs between writes, so the Z80 no longer needs software delay loops.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: request queue entries; power of two, 2..16.
- `ADDR_GAP`, 12: `cen` ticks of recovery after an address-phase strobe.
- `DATA_GAP`, 84: `cen` ticks of recovery after a data-phase strobe.

Ports:
- `clk`  in  1  system clock, 53.6 MHz.
- `RESETn`  in  1  reset, asynchronous assert, active-low.
- `cen`  in  1  OPL clock enable, 4 MHz; the same pulse that drives `jtopl.cen`.
- `req_valid`  in  1  write request present.
- `req_ready`  out  1  FIFO can accept; a push occurs on `req_valid & req_ready`.
- `req_chip`  in  1  target chip: 0 = OPL1, 1 = OPL2.
- `req_reg`  in  8  OPL register index.
- `req_data`  in  8  OPL register value.
- `opl_din`  out  8  shared data bus to both chips.
- `opl_addr`  out  1  0 = address phase, 1 = data phase.
- `opl_cs_n`  out  2  per-chip chip select, active-low; bit 0 = OPL1.
- `opl_wr_n`  out  1  shared write strobe, active-low.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  queued entries.
- `busy`  out  1  FIFO non-empty, FSM not in IDLE, or init running.
- `init_done`  out  1  power-on sequence finished.

## Operation
- FIFO: synchronous and in-order, with no bypass.
  - `req_ready = (fifo_level != FIFO_DEPTH) & init_done`.
  - A push and a pop in the same cycle leave the level unchanged.
  - A push while full is ignored; the producer must honour `req_ready`.
- The FSM has five states: IDLE, ASTB, AWAIT, DSTB, DWAIT.
- IDLE:
  - The head is eligible when the FIFO is non-empty and `timer[head.chip] == 0`.
  - When the head is eligible, the FSM pops it into the working register (chip, reg, data) and goes to ASTB.
  - A head blocked by a busy chip is not overtaken by later entries.
- ASTB:
  - Drives `opl_addr=0`, `opl_din=reg`, `opl_cs_n[chip]=0`, `opl_wr_n=0`.
  - Holds these until a `cen` pulse is seen, then releases all strobes on the next clk.
  - On release it loads `timer[chip]=ADDR_GAP` and goes to AWAIT.
- AWAIT: waits until `timer[chip]==0`, then goes to DSTB.
- DSTB:
  - Same as ASTB, but with `opl_addr=1` and `opl_din=data`.
  - On release it loads `timer[chip]=DATA_GAP` and goes to DWAIT.
- DWAIT: returns to IDLE immediately. The other chip may start a write while this chip's timer is still running.
- Timers:
  - One timer per chip, 8 bits wide.
  - A timer decrements on each `cen` while non-zero and saturates at 0.
  - A load takes priority over a decrement in the same cycle.
- Between strobes `opl_din` holds its last value and `opl_addr` holds its last phase.
- `opl_cs_n` is 11 outside ASTB/DSTB.
- The block never reads from the chips; the CPU still reads status directly.

## Timing
- Reset values:
  - `opl_cs_n=2'b11`, `opl_wr_n=1`, `opl_addr=0`, `opl_din=8'h00`.
  - `fifo_level=0`, `busy=0`, timers 0, FSM IDLE.
  - `init_done` and `req_ready` per Configuration.
- Reset asserted mid-write: strobes deassert asynchronously, the FIFO is flushed, and the in-flight write is lost.
- Latency:
  - Push to pop: one clk when the FIFO is empty and the timer is 0.
  - Pop to first strobe: one clk (ASTB outputs are registered).
  - A strobe is low for between 1 and 14 clk cycles and always contains exactly one `cen` pulse.
- Write spacing per chip:
  - Address to data: ADDR_GAP `cen` ticks plus up to one `cen` period.
  - Data to the next address on the same chip: at least DATA_GAP `cen` ticks.
- `busy` is a registered OR of FIFO non-empty, FSM not in IDLE, and init running.

## Configuration
- `OPL_KEYOFF_INIT_EN` defined:
  - After reset, an internal sequencer injects 18 writes ahead of the FIFO: regs 0xB0..0xB8 = 0x00 on OPL1, then the same on OPL2. This keys off all channels.
  - The writes use the normal FSM path and gaps.
  - `init_done` is 0 until the last DWAIT exits, then 1; `req_ready` is 0 meanwhile.
- `OPL_KEYOFF_INIT_EN` undefined:
  - No sequencer.
  - `init_done` goes to 1 on the first clk after reset release.
  - `req_ready` goes to 1 with `init_done`.

## Test plan
- Single write {chip0, 0x20, 0x21} with `cen` every 13 clk:
  - Address strobe on `cs_n[0]` with `din=0x20`, `addr=0`.
  - Data strobe `din=0x21`, `addr=1`, no earlier than 12 `cen` after the address strobe release.
  - `busy` falls only after FIFO empty and FSM IDLE.
- Four back-to-back chip0 writes (`FIFO_DEPTH=4`):
  - `req_ready` drops at level 4; a fifth push held while not ready is not lost.
  - Consecutive data strobes on chip0 are spaced by at least 84 `cen`.
- Alternating chip0/chip1 writes:
  - The chip1 address strobe starts during the chip0 DWAIT recovery.
  - Bus strobes never overlap and `opl_cs_n` is never 00.
- `cen` stuck low for 100 clk during ASTB: the strobe stays asserted and the timer is frozen; the write completes once `cen` resumes.
- `RESETn` pulsed low during DSTB: strobes high within the same cycle, `fifo_level=0`, no data strobe after release.
- With `OPL_KEYOFF_INIT_EN` defined:
  - Exactly 18 data-phase writes of 0x00 to 0xB0..0xB8, chip0 before chip1.
  - `init_done` rises after the 18th write; `req_ready` is 0 until then.

Source files
------------

// File: rtl/opl_write_scheduler_if.sv
// Request handshake between the sound CPU bridge and opl_write_scheduler.
// The master pushes (chip, reg, data) triples; the slave is the scheduler FIFO.
interface opl_write_scheduler_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_chip;
    logic [7:0] req_reg;
    logic [7:0] req_data;

    modport master (
        output req_valid,
        output req_chip,
        output req_reg,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_chip,
        input  req_reg,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/opl_write_scheduler.sv
// Serializes queued YM3526 writes onto the shared dual-OPL write bus with per-chip recovery timers.
// Optional power-on key-off sequencer enabled by defining OPL_KEYOFF_INIT_EN.
module opl_write_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_GAP   = 12,
    parameter int DATA_GAP   = 84
) (
    input  logic                          clk,
    input  logic                          RESETn,
    input  logic                          cen,
    opl_write_scheduler_if.slave          req,
    output logic [7:0]                    opl_din,
    output logic                          opl_addr,
    output logic [1:0]                    opl_cs_n,
    output logic                          opl_wr_n,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          init_done
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7:0]    AGAP = 8'(ADDR_GAP);
    localparam logic [7:0]    DGAP = 8'(DATA_GAP);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ASTB,
        AWAIT,
        DSTB,
        DWAIT
    } state_t;

    state_t state, state_n;

    // Request FIFO
    logic           mem_chip [FIFO_DEPTH];
    logic [7:0]     mem_reg  [FIFO_DEPTH];
    logic [7:0]     mem_data [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic           push, pop, fifo_nonempty;

    // Write source selected for the next issue (init sequencer or FIFO head)
    logic           src_valid, src_chip;
    logic [7:0]     src_reg, src_data;
    logic           take;
    logic           init_run;

    // Working register; the register index goes straight onto opl_din at pop
    logic           w_chip;
    logic [7:0]     w_data;

    logic [1:0][7:0] timer;
    logic           ld_addr, ld_data;

    logic [7:0]     din_n;
    logic           addr_n, wr_n_n;
    logic [1:0]     cs_n_n;

    function automatic logic [1:0] chip_sel_n(input logic chip);
        return chip ? 2'b01 : 2'b10;
    endfunction

    assign fifo_nonempty = (fifo_level != '0);
    assign req.req_ready = (fifo_level != FULL) & init_done;
    assign push          = req.req_valid & req.req_ready;
    assign take          = (state == IDLE) & src_valid & (timer[src_chip] == '0);

`ifdef OPL_KEYOFF_INIT_EN
    localparam logic [4:0] INIT_WRITES = 5'd18;
    localparam logic [4:0] INIT_PER_CHIP = 5'd9;

    logic [4:0] init_idx, init_off;
    logic       init_pending, init_hi;

    assign init_pending = (init_idx != INIT_WRITES);
    assign init_hi      = (init_idx >= INIT_PER_CHIP);
    assign init_off     = init_hi ? (init_idx - INIT_PER_CHIP) : init_idx;
    assign init_run     = ~init_done;

    always_comb begin
        if (init_pending) begin
            src_valid = 1'b1;
            src_chip  = init_hi;
            src_reg   = 8'hB0 + {3'b000, init_off};
            src_data  = 8'h00;
        end else begin
            src_valid = fifo_nonempty;
            src_chip  = mem_chip[rd_ptr];
            src_reg   = mem_reg[rd_ptr];
            src_data  = mem_data[rd_ptr];
        end
    end

    assign pop = take & ~init_pending;

    // init_done rises as the DWAIT of the final sequencer write exits
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            init_idx  <= '0;
            init_done <= 1'b0;
        end else begin
            if (take && init_pending)
                init_idx <= init_idx + 5'd1;
            if (state == DWAIT && !init_pending)
                init_done <= 1'b1;
        end
    end
`else
    assign init_run  = 1'b0;
    assign src_valid = fifo_nonempty;
    assign src_chip  = mem_chip[rd_ptr];
    assign src_reg   = mem_reg[rd_ptr];
    assign src_data  = mem_data[rd_ptr];
    assign pop       = take;

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn)
            init_done <= 1'b0;
        else
            init_done <= 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem_chip[wr_ptr] <= req.req_chip;
            mem_reg[wr_ptr]  <= req.req_reg;
            mem_data[wr_ptr] <= req.req_data;
        end
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Next state and next registered bus values; strobes hold until released
    always_comb begin
        state_n = state;
        din_n   = opl_din;
        addr_n  = opl_addr;
        cs_n_n  = opl_cs_n;
        wr_n_n  = opl_wr_n;
        ld_addr = 1'b0;
        ld_data = 1'b0;
        case (state)
            IDLE: begin
                if (take) begin
                    state_n = ASTB;
                    din_n   = src_reg;
                    addr_n  = 1'b0;
                    cs_n_n  = chip_sel_n(src_chip);
                    wr_n_n  = 1'b0;
                end
            end
            ASTB: begin
                if (cen) begin
                    state_n = AWAIT;
                    cs_n_n  = 2'b11;
                    wr_n_n  = 1'b1;
                    ld_addr = 1'b1;
                end
            end
            AWAIT: begin
                if (timer[w_chip] == '0) begin
                    state_n = DSTB;
                    din_n   = w_data;
                    addr_n  = 1'b1;
                    cs_n_n  = chip_sel_n(w_chip);
                    wr_n_n  = 1'b0;
                end
            end
            DSTB: begin
                if (cen) begin
                    state_n = DWAIT;
                    cs_n_n  = 2'b11;
                    wr_n_n  = 1'b1;
                    ld_data = 1'b1;
                end
            end
            DWAIT:   state_n = IDLE;
            default: begin
                state_n = IDLE;
                cs_n_n  = 2'b11;
                wr_n_n  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state    <= IDLE;
            opl_din  <= '0;
            opl_addr <= 1'b0;
            opl_cs_n <= '1;
            opl_wr_n <= 1'b1;
            w_chip   <= 1'b0;
            w_data   <= '0;
        end else begin
            state    <= state_n;
            opl_din  <= din_n;
            opl_addr <= addr_n;
            opl_cs_n <= cs_n_n;
            opl_wr_n <= wr_n_n;
            if (take) begin
                w_chip <= src_chip;
                w_data <= src_data;
            end
        end
    end

    // A gap load wins over the cen decrement in the same cycle
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            timer <= '0;
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if ((ld_addr || ld_data) && (w_chip == i[0]))
                    timer[i] <= ld_addr ? AGAP : DGAP;
                else if (cen && timer[i] != '0)
                    timer[i] <= timer[i] - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn)
            busy <= 1'b0;
        else
            busy <= fifo_nonempty | (state != IDLE) | init_run;
    end

endmodule

// File: tb/tb_opl_write_scheduler.sv
// Scoreboard bench for opl_write_scheduler: expected bus strobes are queued at push time
// and a monitor pops and checks them, plus spacing, overlap and busy/ready invariants.
module tb_opl_write_scheduler;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_GAP   = 12;
    localparam int DATA_GAP   = 84;

    logic clk = 1'b0;
    logic RESETn = 1'b0;
    logic cen = 1'b0;
    logic [7:0] opl_din;
    logic       opl_addr;
    logic [1:0] opl_cs_n;
    logic       opl_wr_n;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic busy, init_done;

    opl_write_scheduler_if bus();

    opl_write_scheduler #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .ADDR_GAP(ADDR_GAP),
        .DATA_GAP(DATA_GAP)
    ) dut (
        .clk(clk),
        .RESETn(RESETn),
        .cen(cen),
        .req(bus),
        .opl_din(opl_din),
        .opl_addr(opl_addr),
        .opl_cs_n(opl_cs_n),
        .opl_wr_n(opl_wr_n),
        .fifo_level(fifo_level),
        .busy(busy),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    // cen: one pulse every 13 clk, changed on the falling edge
    int cen_cnt = 0;
    bit cen_en = 1'b1;
    always @(negedge clk) begin
        if (cen_en) begin
            cen_cnt = (cen_cnt == 12) ? 0 : cen_cnt + 1;
            cen = (cen_cnt == 0);
        end else begin
            cen = 1'b0;
        end
    end

    int errors = 0;
    int checks = 0;
    logic [9:0] expq[$];   // {chip, phase, din}

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_write(input logic c, input logic [7:0] r, input logic [7:0] d);
        expq.push_back({c, 1'b0, r});
        expq.push_back({c, 1'b1, d});
    endtask

    task automatic push_init_expect();
`ifdef OPL_KEYOFF_INIT_EN
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 9; i++)
                exp_write(c[0], 8'hB0 + 8'(i), 8'h00);
`endif
    endtask

    // Monitor
    bit prev_wr = 1'b1;
    int prev_level = 0;
    int sp_cnt[2];
    bit sp_valid[2];
    bit last_ph[2];
    int slen, scen;
    bit cur_c;
    bit interleave_seen = 1'b0;
    bit long_ok = 1'b0;

    always @(posedge clk) begin
        logic [9:0] e;
        bit c, rel;
        #1;
        if (!RESETn) begin
            prev_wr = 1'b1;
            prev_level = 0;
            sp_valid[0] = 1'b0;
            sp_valid[1] = 1'b0;
            slen = 0;
            scen = 0;
        end else begin
            checks++;
            if (opl_cs_n == 2'b00 || (opl_wr_n && opl_cs_n != 2'b11)) begin
                errors++;
                $display("FAIL bus_cs: cs_n=%b wr_n=%b at %0t", opl_cs_n, opl_wr_n, $time);
            end
            checks++;
            if (!busy && (prev_level != 0 || prev_wr == 1'b0)) begin
                errors++;
                $display("FAIL busy_early: busy=0 with prev level %0d prev wr_n %0d at %0t",
                         prev_level, prev_wr, $time);
            end
            chk("req_ready", bus.req_ready, (init_done && fifo_level != FIFO_DEPTH) ? 1 : 0);

            rel = 1'b0;
            if (prev_wr && !opl_wr_n) begin
                c = (opl_cs_n == 2'b01);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: cs_n=%b addr=%0d din=0x%0h expected none at %0t",
                             opl_cs_n, opl_addr, opl_din, $time);
                end else begin
                    e = expq.pop_front();
                    chk("strobe_cs_n", opl_cs_n, e[9] ? 2'b01 : 2'b10);
                    chk("strobe_phase", opl_addr, e[8]);
                    chk("strobe_din", opl_din, e[7:0]);
                end
                if (sp_valid[c]) begin
                    if (opl_addr && !last_ph[c])
                        chk("addr_to_data_gap", sp_cnt[c], ADDR_GAP);
                    if (!opl_addr && last_ph[c])
                        chk("data_to_addr_gap_ok", (sp_cnt[c] >= DATA_GAP) ? 1 : 0, 1);
                end
                if (c && !opl_addr && sp_valid[0] && last_ph[0] && sp_cnt[0] < DATA_GAP)
                    interleave_seen = 1'b1;
                cur_c = c;
                slen = 0;
                scen = 0;
            end
            if (!prev_wr) begin
                slen++;
                if (cen) scen++;
            end
            if (!prev_wr && opl_wr_n) begin
                rel = 1'b1;
                chk("strobe_cen_count", scen, 1);
                if (!long_ok)
                    chk("strobe_len_ok", (slen >= 1 && slen <= 14) ? 1 : 0, 1);
                sp_cnt[cur_c] = 0;
                sp_valid[cur_c] = 1'b1;
                last_ph[cur_c] = opl_addr;
            end
            for (int i = 0; i < 2; i++)
                if (cen && sp_valid[i] && !(rel && cur_c == i[0]))
                    sp_cnt[i]++;
            prev_wr = opl_wr_n;
            prev_level = int'(fifo_level);
        end
    end

    task automatic push(input logic c, input logic [7:0] r, input logic [7:0] d);
        bit r_ok;
        int n = 0;
        exp_write(c, r, d);
        bus.req_valid = 1'b1;
        bus.req_chip  = c;
        bus.req_reg   = r;
        bus.req_data  = d;
        do begin
            r_ok = bus.req_ready;
            @(posedge clk);
            #2;
            n++;
        end while (!r_ok && n < 20000);
        bus.req_valid = 1'b0;
        if (!r_ok) chk("push_timeout", 0, 1);
    endtask

    task automatic wait_idle(input string name, input int max);
        bit ok = 1'b0;
        for (int n = 0; n < max && !ok; n++) begin
            @(posedge clk);
            #2;
            ok = (!busy && fifo_level == 0 && expq.size() == 0 && opl_wr_n);
        end
        chk(name, ok, 1);
    endtask

    task automatic wait_init();
`ifdef OPL_KEYOFF_INIT_EN
        bit ok = 1'b0;
        for (int n = 0; n < 40000 && !ok; n++) begin
            @(posedge clk);
            #2;
            ok = init_done;
        end
        chk("init_done_rise", ok, 1);
        chk("init_all_writes_seen", expq.size(), 0);
`else
        chk("init_done_first_clk", init_done, 1);
`endif
    endtask

    task automatic wait_strobe(input string name, input bit phase);
        bit ok = 1'b0;
        for (int n = 0; n < 5000 && !ok; n++) begin
            ok = (!opl_wr_n && opl_addr == phase);
            if (!ok) begin
                @(posedge clk);
                #2;
            end
        end
        chk(name, ok, 1);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_chip  = 1'b0;
        bus.req_reg   = 8'h00;
        bus.req_data  = 8'h00;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_cs_n", opl_cs_n, 2'b11);
        chk("rst_wr_n", opl_wr_n, 1);
        chk("rst_addr", opl_addr, 0);
        chk("rst_din", opl_din, 8'h00);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        RESETn = 1'b1;
        push_init_expect();
        @(posedge clk);
        #2;
        wait_init();

        // Single write with push/pop/strobe latency
        push(1'b0, 8'h20, 8'h21);
        chk("lvl_after_push", fifo_level, 1);
        @(posedge clk);
        #2;
        chk("lvl_after_pop", fifo_level, 0);
        chk("astb_wr_n", opl_wr_n, 0);
        chk("astb_cs_n", opl_cs_n, 2'b10);
        wait_idle("single_done", 20000);

        // Back-to-back chip0 writes fill the FIFO; the sixth push waits for space
        for (int i = 0; i < 6; i++) begin
            push(1'b0, 8'h40 + 8'(i), 8'h10 + 8'(i));
            if (i == 4) begin
                chk("full_level", fifo_level, FIFO_DEPTH);
                chk("full_not_ready", bus.req_ready, 0);
            end
        end
        wait_idle("burst_done", 20000);

        // Alternating chips: chip1 proceeds during chip0 recovery
        interleave_seen = 1'b0;
        push(1'b0, 8'h60, 8'h01);
        push(1'b1, 8'h61, 8'h02);
        push(1'b0, 8'h62, 8'h03);
        push(1'b1, 8'h63, 8'h04);
        wait_idle("alt_done", 20000);
        chk("interleave_seen", interleave_seen, 1);

        // cen stalled during an address strobe
        push(1'b1, 8'h70, 8'h77);
        wait_strobe("stall_strobe_seen", 1'b0);
        long_ok = 1'b1;
        cen_en = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #2;
        end
        chk("stall_wr_n", opl_wr_n, 0);
        chk("stall_cs_n", opl_cs_n, 2'b01);
        chk("stall_din", opl_din, 8'h70);
        cen_en = 1'b1;
        wait_idle("stall_done", 20000);
        long_ok = 1'b0;

        // Reset during a data strobe with a second request still queued
        push(1'b1, 8'h41, 8'h55);
        push(1'b0, 8'h42, 8'h66);
        wait_strobe("dstb_seen", 1'b1);
        chk("dstb_level_before_rst", fifo_level, 1);
        RESETn = 1'b0;
        expq.delete();
        #1;
        chk("rst_mid_wr_n", opl_wr_n, 1);
        chk("rst_mid_cs_n", opl_cs_n, 2'b11);
        chk("rst_mid_level", fifo_level, 0);
        repeat (3) @(posedge clk);
        #2;
        RESETn = 1'b1;
        push_init_expect();
        @(posedge clk);
        #2;
        wait_init();
        repeat (300) @(posedge clk);
        #2;
        chk("post_rst_no_writes", expq.size(), 0);
        chk("post_rst_idle_wr_n", opl_wr_n, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
